// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: coordinate type, default 640x480@60 timings and derived-timing helpers.
package vga_timing_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction
  function automatic int sync_end(int active, int fp, int sync);
    return active + fp + sync;
  endfunction
  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster position, blanking, sync and line/frame markers from the timing source to renderers.
interface vga_timing_if;
  import vga_timing_pkg::*;
  coord_t DrawX;
  coord_t DrawY;
  logic blank;
  logic hs;
  logic vs;
  logic line_start;
  logic frame_start;
  modport master (output DrawX, DrawY, blank, hs, vs, line_start, frame_start);
  modport slave (input DrawX, DrawY, blank, hs, vs, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter for one raster axis; wrap flags the terminal count.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic   vga_clk,
  input  logic   rst_n,
  input  logic   inc,
  input  coord_t term,
  output coord_t count,
  output logic   wrap
);
  assign wrap = count == term;
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing with registered position, blank, sync and markers.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by one pixel so they line up with registered renderer RGB.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input logic vga_clk,
  input logic rst_n,
  input logic pix_ce,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT = coord_t'(V_ACTIVE);
  localparam coord_t H_SS = coord_t'(sync_start(H_ACTIVE, H_FP));
  localparam coord_t H_SE = coord_t'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam coord_t V_SS = coord_t'(sync_start(V_ACTIVE, V_FP));
  localparam coord_t V_SE = coord_t'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  coord_t hc;
  coord_t vc;
  logic h_wrap;
  logic blank_d;
  logic hs_d;
  logic vs_d;
  vga_axis_counter u_h (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .inc(pix_ce),
    .term(H_LAST),
    .count(hc),
    .wrap(h_wrap)
  );
  vga_axis_counter u_v (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .inc(pix_ce & h_wrap),
    .term(V_LAST),
    .count(vc),
    .wrap()
  );
  always_comb begin
    blank_d = (hc < H_ACT) && (vc < V_ACT);
    hs_d = (hc >= H_SS) && (hc < H_SE) ? SYNC_POL : ~SYNC_POL;
    vs_d = (vc >= V_SS) && (vc < V_SE) ? SYNC_POL : ~SYNC_POL;
  end
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      vga.DrawX <= '0;
      vga.DrawY <= '0;
      vga.blank <= 1'b0;
      vga.line_start <= 1'b0;
      vga.frame_start <= 1'b0;
    end else if (pix_ce) begin
      vga.DrawX <= hc;
      vga.DrawY <= vc;
      vga.blank <= blank_d;
      vga.line_start <= hc == '0;
      vga.frame_start <= (hc == '0) && (vc == '0);
    end
`ifdef VGA_SYNC_DELAY_EN
  logic hs_q;
  logic vs_q;
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      vga.hs <= ~SYNC_POL;
      vga.vs <= ~SYNC_POL;
    end else if (pix_ce) begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      vga.hs <= hs_q;
      vga.vs <= vs_q;
    end
`else
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      vga.hs <= ~SYNC_POL;
      vga.vs <= ~SYNC_POL;
    end else if (pix_ce) begin
      vga.hs <= hs_d;
      vga.vs <= vs_d;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default 640x480 instance and a tiny active-high-sync instance.
module tb_vga_timing_gen;
`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif
  logic vga_clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  int errors = 0;
  int checks = 0;
  int d_pos_err = 0, d_mark_err = 0, d_blank = 0, d_unblank = -1, d_hs = 0, d_hs_first = -1, d_hs_last = -1;
  int d_vs_low = 0, d_ls = 0;
  int s_pos_err = 0, s_mark_err = 0, s_blank_err = 0, s_blank = 0, s_vs = 0, s_vs_first = -1, s_vs_last = -1;
  int s_hs = 0, s_hs_first = -1, s_fs = 0, s_fs2 = -1;
  int c_pos_err = 0, c_mark_err = 0, c_ls = 0, c_r1 = -1, c_r2 = -1;
  logic prev_fs = 1'b0;
  vga_timing_if d_if ();
  vga_timing_if s_if ();
  vga_timing_gen u_d (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .vga(d_if)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_s (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .vga(s_if)
  );
  always #5 vga_clk = ~vga_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask
  initial begin
    pix_ce = 1'b1;
    repeat (3) @(negedge vga_clk);
    rst_n = 1'b1;
    repeat (50) @(negedge vga_clk);
    check("pre_rst_d_x", d_if.DrawX, 49);
    check("pre_rst_s_y", s_if.DrawY, 3);
    @(posedge vga_clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_d_x", d_if.DrawX, 0);
    check("rst_d_blank", d_if.blank, 0);
    check("rst_d_hs", d_if.hs, 1);
    check("rst_d_vs", d_if.vs, 1);
    check("rst_d_ls", d_if.line_start, 0);
    check("rst_d_fs", d_if.frame_start, 0);
    check("rst_s_x", s_if.DrawX, 0);
    check("rst_s_y", s_if.DrawY, 0);
    check("rst_s_hs", s_if.hs, 0);
    check("rst_s_vs", s_if.vs, 0);
    repeat (2) @(negedge vga_clk);
    check("rst_hold_s_x", s_if.DrawX, 0);
    check("rst_hold_d_blank", d_if.blank, 0);
    rst_n = 1'b1;
    @(negedge vga_clk);
    check("first_d_x", d_if.DrawX, 0);
    check("first_d_y", d_if.DrawY, 0);
    check("first_d_blank", d_if.blank, 1);
    check("first_d_fs", d_if.frame_start, 1);
    check("first_d_ls", d_if.line_start, 1);
    for (int i = 0; i < 1700; i++) begin
      if (i > 0) @(negedge vga_clk);
      if (d_if.DrawX !== 10'(i % 800) || d_if.DrawY !== 10'(i / 800)) d_pos_err++;
      if (d_if.line_start !== (i % 800 == 0) || d_if.frame_start !== (i == 0)) d_mark_err++;
      if (d_if.line_start) d_ls++;
      if (d_if.vs !== 1'b1) d_vs_low++;
      if (i < 800) begin
        if (d_if.blank) d_blank++;
        else if (d_unblank < 0) d_unblank = i;
        if (!d_if.hs) begin
          d_hs++;
          if (d_hs_first < 0) d_hs_first = int'(d_if.DrawX);
          d_hs_last = int'(d_if.DrawX);
        end
      end
      if (s_if.DrawX !== 10'(i % 15) || s_if.DrawY !== 10'((i / 15) % 8)) s_pos_err++;
      if (s_if.line_start !== (i % 15 == 0) || s_if.frame_start !== (i % 120 == 0)) s_mark_err++;
      if (s_if.blank !== ((i % 15 < 8) && ((i / 15) % 8 < 4))) s_blank_err++;
      if (s_if.frame_start) begin
        s_fs++;
        if (i > 0 && s_fs2 < 0) s_fs2 = i;
      end
      if (i < 120) begin
        if (s_if.blank) s_blank++;
        if (s_if.vs) begin
          s_vs++;
          if (s_vs_first < 0) s_vs_first = int'(s_if.DrawY);
          s_vs_last = int'(s_if.DrawY);
        end
      end
      if (i < 15 && s_if.hs) begin
        s_hs++;
        if (s_hs_first < 0) s_hs_first = int'(s_if.DrawX);
      end
    end
    check("d_pos", d_pos_err, 0);
    check("d_marks", d_mark_err, 0);
    check("d_ls_cnt", d_ls, 3);
    check("d_vs_idle", d_vs_low, 0);
    check("d_blank_cnt", d_blank, 640);
    check("d_unblank_x", d_unblank, 640);
    check("d_hs_cnt", d_hs, 96);
    check("d_hs_first", d_hs_first, 656 + SD);
    check("d_hs_last", d_hs_last, 751 + SD);
    check("s_pos", s_pos_err, 0);
    check("s_marks", s_mark_err, 0);
    check("s_blank_map", s_blank_err, 0);
    check("s_blank_cnt", s_blank, 32);
    check("s_fs_cnt", s_fs, 15);
    check("s_fs_period", s_fs2, 120);
    check("s_vs_cnt", s_vs, 30);
    check("s_vs_first", s_vs_first, 5);
    check("s_vs_last", s_vs_last, 6 + SD);
    check("s_hs_cnt", s_hs, 3);
    check("s_hs_first", s_hs_first, 10 + SD);
    rst_n = 1'b0;
    pix_ce = 1'b0;
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
    pix_ce = 1'b1;
    for (int c = 0; c < 600; c++) begin
      int pos;
      @(negedge vga_clk);
      pos = c / 2;
      if (s_if.DrawX !== 10'(pos % 15) || s_if.DrawY !== 10'((pos / 15) % 8)) c_pos_err++;
      if (d_if.DrawX !== 10'(pos % 800) || d_if.DrawY !== 10'(pos / 800)) c_pos_err++;
      if (s_if.line_start !== (pos % 15 == 0) || s_if.frame_start !== (pos % 120 == 0)) c_mark_err++;
      if (c < 30 && s_if.line_start) c_ls++;
      if (s_if.frame_start && !prev_fs) begin
        if (c_r1 < 0) c_r1 = c;
        else if (c_r2 < 0) c_r2 = c;
      end
      prev_fs = s_if.frame_start;
      pix_ce = ((c + 1) % 2 == 0);
    end
    check("ce_pos_hold", c_pos_err, 0);
    check("ce_marks", c_mark_err, 0);
    check("ce_ls_width", c_ls, 2);
    check("ce_fs_first", c_r1, 0);
    check("ce_fs_period", c_r2 - c_r1, 240);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
